ser_frame_rx_ctrl: RTL
======================

Name: ser_frame_rx_ctrl

Overview:
- Upstream controller for the shift-register stage.
- Receives an asynchronous UART-style serial line: start bit, N data bits MSB-first, one stop bit.
- Drives the shift register's serial `data` input and its `shift` and `set` strobes.
- A complete, correctly framed word therefore appears on the shift register's parallel output.

Parameters:
- N, 8, data bits per frame; must equal the downstream shift-register width.
- OVS, 16, clk cycles per serial bit; must be even and >= 4.
- CNT_W, $clog2(OVS), width of the oversampling divider (derived; not to be overridden).
- BIT_W, $clog2(N+1), width of the bit counter (derived).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx  in  1  raw serial line, idle high, asynchronous to clk
- en  in  1  receive enable; low aborts/blocks reception
- data  out  1  sampled bit, valid in the same cycle as shift
- shift  out  1  one-cycle strobe: downstream shifts in data
- set  out  1  one-cycle strobe: downstream copies its buffer to its output (frame good)
- busy  out  1  high while FSM is not IDLE
- frame_err  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (reset=0, async):
  - data=0, shift=0, set=0, busy=0, frame_err=0.
  - FSM=IDLE, divider=0, bit counter=0.
  - Both synchronizer flops=1.
  - All outputs are registered.
- Synchronizer: 2-flop on rx produces rx_s; a third flop rx_d gives edge detection. Pin-to-rx_s latency is 2 clk.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On rx_d=1, rx_s=0 and en=1 -> START, divider=0. Call this cycle T0.
  - Otherwise stay; busy=0.
- START:
  - Divider counts 0..OVS/2-1.
  - At OVS/2-1: rx_s=0 -> DATA, divider=0, bit counter=0.
  - rx_s=1 -> false start -> IDLE with no strobes.
- DATA:
  - Divider counts 0..OVS-1.
  - At OVS-1: register data<=rx_s and shift<=1 for exactly one cycle; bit counter+1.
  - After the N-th sample -> STOP, divider=0.
  - Bit k (k=0..N-1, MSB first) is sampled at T0+OVS/2+OVS*(k+1) and is visible on data/shift one cycle later.
- STOP:
  - At divider OVS-1: rx_s=1 -> set=1 for one cycle; rx_s=0 -> frame_err=1 for one cycle, set stays 0.
  - Either way -> IDLE.
- set never coincides with shift; it always follows the last shift by OVS cycles.
- en=0 in any non-IDLE state: next cycle -> IDLE, divider and bit counter cleared, no set and no frame_err. Partial bits already shifted downstream are left there.
- Re-arm after a stop error: a new start needs a fresh 1->0 edge. A line held low after a bad stop does not retrigger.
- Back-to-back frames: a start edge is accepted in the cycle after STOP returns to IDLE. No idle gap is required beyond the stop bit.
- Reset mid-frame: immediate return to reset values. The next complete frame is received correctly.
- Divider and bit counter never wrap outside their defined ranges; both are cleared on every state entry.

Decomposition:
- Package ser_rx_pkg holds:
  - the state enum type (IDLE/START/DATA/STOP, 2-bit encoding);
  - default parameter constants (N_DEF=8, OVS_DEF=16).
- One sub-module, rx_sync: 2-flop synchronizer plus edge flop. It outputs rx_s and fall = rx_d & ~rx_s, with reset value 1 on all flops.
- Divider, bit counter and FSM stay in the top module.

Test Plan (N=8, OVS=16; line driven at 16 clk/bit; downstream shift register instantiated with its wri=0):
- Frame 0xA5, stop=1, en=1 -> 8 shift pulses 16 clk apart with data 1,0,1,0,0,1,0,1; one set pulse 16 clk after the last shift; frame_err=0; downstream parallel output = 0xA5.
- rx low for 4 clk then high (glitch) -> START entered, then returns to IDLE at the mid-bit check; zero shift/set; busy high for 8 clk then 0.
- Frame 0x3C with stop bit 0 -> 8 shifts (data 0,0,1,1,1,1,0,0); frame_err pulse of exactly 1 cycle; no set; downstream output unchanged; line held low for 40 clk -> no new frame.
- en deasserted 2 clk after the 3rd shift of frame 0xFF -> FSM IDLE next cycle; no further shifts; no set; re-enable plus a new frame 0x81 -> output 0x81.
- reset pulsed low during bit 5 of a frame -> all outputs 0 asynchronously, busy=0; following frame 0x5A received with set and output 0x5A.
- Back-to-back frames 0x00 then 0xFF with a single stop bit between -> 16 shifts, 2 set pulses, outputs 0x00 then 0xFF, frame_err never high.

Source files
------------

// File: rtl/ser_rx_pkg.sv
// Shared types and default sizing for the serial frame receiver.
package ser_rx_pkg;

    localparam int N_DEF   = 8;
    localparam int OVS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ser_frame_rx_ctrl_rx_sync.sv
// Two-flop synchronizer for the raw serial line plus an edge flop for start detection.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_d;

    // Flops reset to the idle-high line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_d  <= 1'b1;
        end else begin
            r_s1 <= rx;
            r_s2 <= r_s1;
            r_d  <= r_s2;
        end
    end

    assign rx_s = r_s2;
    assign fall = r_d & ~r_s2;

endmodule

// File: rtl/ser_frame_rx_ctrl.sv
// Oversampling serial frame receiver: drives data/shift/set of a downstream shift register.
module ser_frame_rx_ctrl
    import ser_rx_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int OVS   = OVS_DEF,
    parameter int CNT_W = $clog2(OVS),
    parameter int BIT_W = $clog2(N + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic en,
    output logic data,
    output logic shift,
    output logic set,
    output logic busy,
    output logic frame_err
);

    localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] DIV_FULL = CNT_W'(OVS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    logic w_rx_s;
    logic w_fall;

    rx_state_t        r_state;
    rx_state_t        w_state_next;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_next;
    logic [BIT_W-1:0] r_bit;
    logic [BIT_W-1:0] w_bit_next;
    logic             r_data;
    logic             w_data_next;
    logic             r_shift;
    logic             w_shift_next;
    logic             r_set;
    logic             w_set_next;
    logic             r_busy;
    logic             w_busy_next;
    logic             r_ferr;
    logic             w_ferr_next;

    rx_sync u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (w_rx_s),
        .fall  (w_fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_data  <= 1'b0;
            r_shift <= 1'b0;
            r_set   <= 1'b0;
            r_busy  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_data  <= w_data_next;
            r_shift <= w_shift_next;
            r_set   <= w_set_next;
            r_busy  <= w_busy_next;
            r_ferr  <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_data_next  = r_data;
        w_shift_next = 1'b0;
        w_set_next   = 1'b0;
        w_ferr_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_fall && en) begin
                    w_state_next = START;
                    w_div_next   = '0;
                    w_bit_next   = '0;
                end
            end
            START: begin
                if (r_div == DIV_HALF) begin
                    w_state_next = w_rx_s ? IDLE : DATA;
                    w_div_next   = '0;
                    w_bit_next   = '0;
                end else begin
                    w_div_next = r_div + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_div == DIV_FULL) begin
                    w_data_next  = w_rx_s;
                    w_shift_next = 1'b1;
                    w_div_next   = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_next = STOP;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_div_next = r_div + CNT_W'(1);
                end
            end
            STOP: begin
                if (r_div == DIV_FULL) begin
                    w_set_next   = w_rx_s;
                    w_ferr_next  = ~w_rx_s;
                    w_state_next = IDLE;
                    w_div_next   = '0;
                end else begin
                    w_div_next = r_div + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_div_next   = '0;
                w_bit_next   = '0;
            end
        endcase

        // Dropping enable abandons the frame outright, even on a sampling cycle.
        if (r_state != IDLE && !en) begin
            w_state_next = IDLE;
            w_div_next   = '0;
            w_bit_next   = '0;
            w_data_next  = r_data;
            w_shift_next = 1'b0;
            w_set_next   = 1'b0;
            w_ferr_next  = 1'b0;
        end

        w_busy_next = (w_state_next != IDLE);
    end

    assign data      = r_data;
    assign shift     = r_shift;
    assign set       = r_set;
    assign busy      = r_busy;
    assign frame_err = r_ferr;

endmodule
